bin_cnt_src: RTL and testbench
==============================

Name: bin_cnt_src

Overview:
Prescaled binary up/down counter that produces the 4-bit binary word consumed directly downstream by the binary-to-Gray converter. It supports enable, synchronous load, direction control, wrap or saturate mode, and a terminal-count pulse. Its registered output b[WIDTH-1:0] connects bit-for-bit to the converter inputs b3..b0, with b[3] as the MSB.

Parameters:
WIDTH, 4, counter width in bits. Must be 4 when driving the converter.
DIV, 1, prescale ratio. One count step per DIV enabled cycles; legal range DIV >= 1.
PW, $clog2(DIV) with a minimum of 1, local. Prescaler width; not overridable.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-high.
en  input  1  count enable; advances the prescaler.
up  input  1  direction: 1 = increment, 0 = decrement; sampled on tick cycles only.
ld  input  1  synchronous load strobe.
ld_val  input  WIDTH  load value.
sat  input  1  1 = saturate at bounds, 0 = wrap around.
b  output  WIDTH  registered binary count, fed to the Gray converter.
upd  output  1  registered one-cycle strobe: a step was taken (including a saturated hold) or a load occurred.
tc  output  1  registered one-cycle terminal-count pulse.

Behaviour:
- One clock: clk. Reset is asynchronous and active-high (rst). On rst: b=0, prescaler=0, upd=0, tc=0. Release is synchronous to the next clk edge.
- Priority per cycle: rst > ld > en > hold.
- ld=1: b <= ld_val, prescaler <= 0, upd <= 1, tc <= 0. This applies regardless of en, up or sat.
- en=0 with ld=0: b and prescaler hold; upd <= 0; tc <= 0.
- en=1 with ld=0:
  - Prescaler counts 0..DIV-1.
  - tick = en && prescaler == DIV-1; the prescaler returns to 0 on tick.
  - With DIV=1, every enabled cycle is a tick.
- On a tick, step with MAX = 2^WIDTH-1:
  - up=1, b<MAX: b <= b+1.
  - up=1, b==MAX: b <= 0 if sat=0, else b holds MAX. tc <= 1 in both cases.
  - up=0, b>0: b <= b-1.
  - up=0, b==0: b <= MAX if sat=0, else b holds 0. tc <= 1 in both cases.
  - upd <= 1 on every tick.
- On non-tick cycles: upd <= 0, tc <= 0.
- Latency: a tick at edge N updates b, upd and tc together, visible after edge N. The downstream Gray code is valid in the same cycle, since the converter is combinational.
- Direction changes between ticks have no effect until the next tick samples up. The prescaler phase is preserved.
- Dropping en mid-prescale freezes the phase; counting resumes from the same phase.
- ld coincident with a tick: load wins and the step is discarded; tc=0.
- Reset mid-operation: everything clears immediately, without waiting for clk.
- All arithmetic is modulo 2^WIDTH. There are no combinational paths from inputs to outputs.

Decomposition:
- Package bin_cnt_pkg holds:
  - CNT_W = 4 (matches the converter width).
  - function cnt_max(w) returning 2^w-1.
  - dir encoding constants DIR_UP=1'b1 and DIR_DN=1'b0.
- One sub-module is natural: tick_gen (params DIV, PW; ports clk, rst, en, clr, tick). It contains the prescaler; clr is driven by ld.
- The counter/flag logic stays in bin_cnt_src.

Test Plan:
1. Wrap up (DIV=1, sat=0): rst, then ld ld_val=4'd14, then en=1 up=1 for 3 cycles. Required: b = 15, 0, 1; tc high only in the cycle b=0; upd high in all 3 cycles.
2. Saturate down (DIV=1, sat=1): ld 4'd1, then en=1 up=0 for 3 cycles. Required: b = 0, 0, 0; tc high in cycles 2 and 3; upd high in all 3.
3. Prescale (DIV=3): en=1 up=1 from b=0 for 9 cycles. Required: b changes only after cycles 3, 6 and 9 (to 1, 2, 3). Separately, deassert en for 2 cycles after cycle 4: the next step arrives 2 cycles later than it otherwise would.
4. Load priority (DIV=3): ld=1 ld_val=4'd9 on a tick cycle with en=1. Required: b=9, tc=0, upd=1; next step occurs 3 enabled cycles later (b=10).
5. Direction change mid-prescale (DIV=3): up=1 for 2 cycles, then up=0 on the tick cycle from b=5. Required: b=4.
6. Async reset: assert rst between clk edges while b=7 with a tick pending. Required: b=0, upd=0, tc=0 immediately; first step after release needs DIV enabled cycles.

Source files
------------

// File: rtl/bin_cnt_pkg.sv
// Shared constants for the binary counter that feeds the binary-to-Gray converter.
package bin_cnt_pkg;

  localparam int CNT_W = 4;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/bin_cnt_src_tick_gen.sv
// Prescaler: emits one tick per DIV enabled cycles; phase freezes while en is low.
module tick_gen #(
  parameter int DIV = 1,
  parameter int PW  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/bin_cnt_src.sv
// Prescaled up/down binary counter with load, wrap/saturate and terminal-count pulse.
module bin_cnt_src
  import bin_cnt_pkg::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             sat,
  output logic [WIDTH-1:0] b,
  output logic             upd,
  output logic             tc
);

  localparam int              PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

  logic             tick;
  logic [WIDTH-1:0] step_b;
  logic             step_tc;

  tick_gen #(
    .DIV (DIV),
    .PW  (PW)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (ld),
    .tick (tick)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    step_b  = b;
    step_tc = 1'b0;
    if (up == DIR_UP) begin
      if (b == MAX) begin
        step_tc = 1'b1;
        step_b  = sat ? MAX : '0;
      end else begin
        step_b  = b + WIDTH'(1);
      end
    end else begin
      if (b == '0) begin
        step_tc = 1'b1;
        step_b  = sat ? '0 : MAX;
      end else begin
        step_b  = b - WIDTH'(1);
      end
    end
  end

  // Load outranks a coincident tick: the step is discarded and tc stays low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b   <= '0;
      upd <= 1'b0;
      tc  <= 1'b0;
    end else if (ld) begin
      b   <= ld_val;
      upd <= 1'b1;
      tc  <= 1'b0;
    end else if (tick) begin
      b   <= step_b;
      upd <= 1'b1;
      tc  <= step_tc;
    end else begin
      upd <= 1'b0;
      tc  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bin_cnt_src.sv
// Directed bench: one DIV=1 and one DIV=3 instance share stimulus; each test checks its target.
module tb_bin_cnt_src;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, ld, sat;
  logic [3:0] ld_val;
  logic [3:0] b1, b3;
  logic       upd1, tc1, upd3, tc3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bin_cnt_src #(.WIDTH(4), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .ld_val(ld_val), .sat(sat),
    .b(b1), .upd(upd1), .tc(tc1)
  );

  bin_cnt_src #(.WIDTH(4), .DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .ld_val(ld_val), .sat(sat),
    .b(b3), .upd(upd3), .tc(tc3)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one edge and settle 1 ns past it; inputs are changed afterwards.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; sat = 1'b0; ld_val = '0;
    #12;
    check("rst_b1", b1, 0);   check("rst_upd1", upd1, 0); check("rst_tc1", tc1, 0);
    check("rst_b3", b3, 0);   check("rst_upd3", upd3, 0); check("rst_tc3", tc3, 0);
    step();
    rst = 1'b0;

    // 1. wrap up, DIV=1
    ld = 1'b1; ld_val = 4'd14;
    step();
    check("t1_ld_b", b1, 14); check("t1_ld_upd", upd1, 1); check("t1_ld_tc", tc1, 0);
    ld = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
    step(); check("t1_c1_b", b1, 15); check("t1_c1_tc", tc1, 0); check("t1_c1_upd", upd1, 1);
    step(); check("t1_c2_b", b1, 0);  check("t1_c2_tc", tc1, 1); check("t1_c2_upd", upd1, 1);
    step(); check("t1_c3_b", b1, 1);  check("t1_c3_tc", tc1, 0); check("t1_c3_upd", upd1, 1);

    // 2. saturate down, DIV=1
    en = 1'b0; sat = 1'b1; ld = 1'b1; ld_val = 4'd1;
    step(); check("t2_ld_b", b1, 1);
    ld = 1'b0; en = 1'b1; up = 1'b0;
    step(); check("t2_c1_b", b1, 0); check("t2_c1_tc", tc1, 0); check("t2_c1_upd", upd1, 1);
    step(); check("t2_c2_b", b1, 0); check("t2_c2_tc", tc1, 1); check("t2_c2_upd", upd1, 1);
    step(); check("t2_c3_b", b1, 0); check("t2_c3_tc", tc1, 1); check("t2_c3_upd", upd1, 1);

    // 3a. prescale, DIV=3: steps after cycles 3, 6, 9
    en = 1'b0; sat = 1'b0; up = 1'b1;
    pulse_rst();
    check("t3_rst_b", b3, 0);
    en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      check($sformatf("t3_c%0d_b", i), b3, i / 3);
      check($sformatf("t3_c%0d_upd", i), upd3, (i % 3 == 0) ? 1 : 0);
    end

    // 3b. en dropped for 2 cycles after cycle 4 delays the next step by 2
    en = 1'b0;
    pulse_rst();
    en = 1'b1;
    for (int i = 1; i <= 4; i++) step();
    check("t3b_c4_b", b3, 1);
    en = 1'b0;
    step(); step();
    check("t3b_frz_b", b3, 1); check("t3b_frz_upd", upd3, 0);
    en = 1'b1;
    step(); check("t3b_c7_b", b3, 1);
    step(); check("t3b_c8_b", b3, 2); check("t3b_c8_upd", upd3, 1);

    // 4. load on a tick cycle (prescaler now 0, b=2)
    step(); step();
    check("t4_pre_b", b3, 2);
    ld = 1'b1; ld_val = 4'd9;
    step(); check("t4_ld_b", b3, 9); check("t4_ld_tc", tc3, 0); check("t4_ld_upd", upd3, 1);
    ld = 1'b0;
    step(); check("t4_e1_b", b3, 9); check("t4_e1_upd", upd3, 0);
    step(); check("t4_e2_b", b3, 9);
    step(); check("t4_e3_b", b3, 10); check("t4_e3_upd", upd3, 1);

    // 5. direction flips on the tick cycle
    en = 1'b0; ld = 1'b1; ld_val = 4'd5;
    step(); check("t5_ld_b", b3, 5);
    ld = 1'b0; en = 1'b1; up = 1'b1;
    step(); step();
    check("t5_mid_b", b3, 5);
    up = 1'b0;
    step(); check("t5_tick_b", b3, 4); check("t5_tick_tc", tc3, 0);

    // 6. async reset between edges with a tick pending
    en = 1'b0; ld = 1'b1; ld_val = 4'd7;
    step(); check("t6_ld_b", b3, 7); check("t6_ld_upd", upd3, 1);
    ld = 1'b0; en = 1'b1; up = 1'b1;
    step(); step();
    check("t6_pend_b", b3, 7);
    #2 rst = 1'b1;
    #1;
    check("t6_async_b", b3, 0); check("t6_async_upd", upd3, 0); check("t6_async_tc", tc3, 0);
    #1 rst = 1'b0;
    step(); check("t6_r1_b", b3, 0);
    step(); check("t6_r2_b", b3, 0);
    step(); check("t6_r3_b", b3, 1); check("t6_r3_upd", upd3, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
